spi_peripheral: RTL

SPI_PERIPHERAL -- requirements
Module: spi_peripheral

---
 rtl/spi_peripheral.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/spi_peripheral.sv
// SPI mode-0 peripheral: 16-bit frames write a small register file feeding the PWM/output stage.
// Define SPI_READBACK_EN to build the cipo readback path; otherwise cipo is tied low.
module spi_peripheral #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MAX_ADDR    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ncs,
  input  logic       sclk,
  input  logic       copi,
  output logic       cipo,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle
);

  localparam int unsigned NUM_REGS   = 5;
  localparam logic [6:0]  MAX_ADDR_L = 7'(MAX_ADDR);
  localparam logic [4:0]  CNT_FULL   = 5'd16;
  localparam logic [4:0]  CNT_SAT    = 5'd17;

  typedef enum logic {
    FRAME_IDLE,
    FRAME_ACTIVE
  } frame_state_e;

  logic [SYNC_STAGES-1:0] ncs_sync_q;
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] copi_sync_q;
  logic                   ncs_prev_q;
  logic                   sclk_prev_q;

  logic ncs_s;
  logic sclk_s;
  logic copi_s;
  logic ncs_fall;
  logic ncs_rise;
  logic sclk_rise;
  logic shift_en;

  frame_state_e state_q, state_d;
  logic [15:0]  shift_q, shift_d;
  logic [4:0]   cnt_q, cnt_d;
  logic         commit;
  logic [7:0]   regs_q [NUM_REGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ncs_sync_q  <= '0;
      sclk_sync_q <= '0;
      copi_sync_q <= '0;
      ncs_prev_q  <= 1'b0;
      sclk_prev_q <= 1'b0;
    end else begin
      ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], ncs};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], copi};
      ncs_prev_q  <= ncs_sync_q[SYNC_STAGES-1];
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
    end
  end

  assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign copi_s    = copi_sync_q[SYNC_STAGES-1];
  assign ncs_fall  = ncs_prev_q & ~ncs_s;
  assign ncs_rise  = ~ncs_prev_q & ncs_s;
  assign sclk_rise = ~sclk_prev_q & sclk_s;

  // Only frames opened by an observed ncs fall are accepted, so a reset
  // mid-frame leaves the rest of that frame ignored.
  assign shift_en = sclk_rise & ~ncs_s & (state_q == FRAME_ACTIVE);

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    if (ncs_fall) begin
      state_d = FRAME_ACTIVE;
      shift_d = '0;
      cnt_d   = '0;
    end else if (ncs_rise) begin
      state_d = FRAME_IDLE;
      commit  = (state_q == FRAME_ACTIVE) && (cnt_q == CNT_FULL) &&
                shift_q[15] && (shift_q[14:8] <= MAX_ADDR_L);
    end else if (shift_en) begin
      shift_d = {shift_q[14:0], copi_s};
      if (cnt_q != CNT_SAT) begin
        cnt_d = cnt_q + 5'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FRAME_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (commit) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (shift_q[14:8] == 7'(i)) begin
          regs_q[i] <= shift_q[7:0];
        end
      end
    end
  end

  assign en_reg_out_7_0  = regs_q[0];
  assign en_reg_out_15_8 = regs_q[1];
  assign en_reg_pwm_7_0  = regs_q[2];
  assign en_reg_pwm_15_8 = regs_q[3];
  assign pwm_duty_cycle  = regs_q[4];

`ifdef SPI_READBACK_EN
  logic       sclk_fall;
  logic [6:0] rd_addr;
  logic [7:0] rd_data;
  logic [7:0] tx_q, tx_d;

  assign sclk_fall = sclk_prev_q & ~sclk_s;
  // On the 8th rise the header's last address bit is still on copi_s.
  assign rd_addr   = {shift_q[5:0], copi_s};

  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (rd_addr == 7'(i)) begin
        rd_data = regs_q[i];
      end
    end
  end

  // The fall right after the load is skipped so bit 7 is presented on the 9th rise.
  always_comb begin
    tx_d = tx_q;
    if (ncs_fall) begin
      tx_d = '0;
    end else if (shift_en && (cnt_q == 5'd7)) begin
      tx_d = (!shift_q[6] && (rd_addr <= MAX_ADDR_L)) ? rd_data : '0;
    end else if (sclk_fall && !ncs_s && (cnt_q >= 5'd9)) begin
      tx_d = {tx_q[6:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_q <= '0;
    end else begin
      tx_q <= tx_d;
    end
  end

  assign cipo = tx_q[7] & ~ncs_s;
`else
  assign cipo = 1'b0;
`endif

endmodule
